// File: rtl/debug_unit_if.sv
// debug_unit_if -- bundles the UART byte handshake, pipeline control and
// instruction-memory write port seen by debug_unit.
//   UART rx : rx_done (byte strobe), rx_data (byte)
//   UART tx : tx_start (byte pending), tx_data (byte), tx_done (byte sent)
//   CPU     : halt_detected (halt retired), cpu_enable, cpu_reset
//   IMEM    : imem_wr_en (write strobe), imem_addr (word address), imem_data
// Modport master is the debug unit; slave is the surrounding system.
interface debug_unit_if #(
    parameter int LEN      = 32,
    parameter int ADDR_LEN = 10
);
    logic                rx_done;
    logic [7:0]          rx_data;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_done;
    logic                halt_detected;
    logic                cpu_enable;
    logic                cpu_reset;
    logic                imem_wr_en;
    logic [ADDR_LEN-1:0] imem_addr;
    logic [LEN-1:0]      imem_data;

    modport master (
        input  rx_done, rx_data, tx_done, halt_detected,
        output tx_start, tx_data, cpu_enable, cpu_reset,
               imem_wr_en, imem_addr, imem_data
    );

    modport slave (
        output rx_done, rx_data, tx_done, halt_detected,
        input  tx_start, tx_data, cpu_enable, cpu_reset,
               imem_wr_en, imem_addr, imem_data
    );
endinterface

// File: rtl/debug_unit.sv
// debug_unit -- byte-level loader and run controller for the MIPS pipeline.
// Consumes the host byte stream (START, LSB-first 32-bit instructions, then
// run-mode commands), writes the program into instruction memory, gates the
// pipeline enable for continuous or single-step execution and reports the
// executed cycle count back as four LSB-first bytes.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   dbg   : debug_unit_if.master (UART rx/tx, CPU control, IMEM write port)
// All outputs are registered.
module debug_unit #(
    parameter int LEN      = 32,
    parameter int ADDR_LEN = 10
) (
    input  logic         clk,
    input  logic         reset,
    debug_unit_if.master dbg
);

    localparam logic [7:0] CMD_START      = 8'h01;
    localparam logic [7:0] CMD_CONTINUOUS = 8'h02;
    localparam logic [7:0] CMD_STEP_MODE  = 8'h03;
    localparam logic [7:0] CMD_REPROGRAM  = 8'h05;
    localparam logic [7:0] CMD_STEP       = 8'h06;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_PROG      = 4'd1;
    localparam logic [3:0] ST_WRITE     = 4'd2;
    localparam logic [3:0] ST_WAIT_MODE = 4'd3;
    localparam logic [3:0] ST_RUN       = 4'd4;
    localparam logic [3:0] ST_STEP_IDLE = 4'd5;
    localparam logic [3:0] ST_STEP_EXEC = 4'd6;
    localparam logic [3:0] ST_SEND      = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;

    logic [3:0]          state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         cycle_count_q, cycle_count_d;
    logic                halted_q, halted_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                cpu_enable_q, cpu_enable_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                imem_wr_en_q, imem_wr_en_d;
    logic [ADDR_LEN-1:0] imem_addr_q, imem_addr_d;
    logic [LEN-1:0]      imem_data_q, imem_data_d;

    logic [31:0]         count_inc;
    logic [1:0]          next_idx;
    logic                start_prog;

    assign count_inc = cycle_count_q + 32'd1;
    assign next_idx  = byte_idx_q + 2'd1;

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        cycle_count_d = cycle_count_q;
        halted_d      = halted_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        cpu_enable_d  = cpu_enable_q;
        cpu_reset_d   = cpu_reset_q;
        imem_wr_en_d  = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_data_d   = imem_data_q;
        start_prog    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cpu_reset_d  = 1'b1;
                cpu_enable_d = 1'b0;
                if (dbg.rx_done && dbg.rx_data == CMD_START) begin
                    start_prog = 1'b1;
                end
            end

            ST_PROG: begin
                if (dbg.rx_done) begin
                    imem_data_d[{byte_idx_q, 3'b000} +: 8] = dbg.rx_data;
                    byte_idx_d = next_idx;
                    if (byte_idx_q == 2'd3) begin
                        state_d      = ST_WRITE;
                        imem_wr_en_d = 1'b1;
                    end
                end
            end

            // Strobe is high during this state; the address advances on exit
            // so the write sees a stable address. Wrap at 2^ADDR_LEN is natural.
            ST_WRITE: begin
                imem_addr_d = imem_addr_q + 1'b1;
                byte_idx_d  = 2'd0;
                if (imem_data_q[LEN-1 -: 6] == 6'b111111) begin
                    state_d = ST_WAIT_MODE;
                end else begin
                    state_d = ST_PROG;
                end
            end

            ST_WAIT_MODE: begin
                if (dbg.rx_done) begin
                    case (dbg.rx_data)
                        CMD_CONTINUOUS: begin
                            state_d      = ST_RUN;
                            cpu_reset_d  = 1'b0;
                            cpu_enable_d = 1'b1;
                        end
                        CMD_STEP_MODE: begin
                            state_d      = ST_STEP_IDLE;
                            cpu_reset_d  = 1'b0;
                            cpu_enable_d = 1'b0;
                        end
                        CMD_REPROGRAM: start_prog = 1'b1;
                        default: ;
                    endcase
                end
            end

            // The cycle in which halt is sampled still counts; the first
            // count byte is taken from the incremented value.
            ST_RUN: begin
                cycle_count_d = count_inc;
                if (dbg.halt_detected) begin
                    halted_d     = 1'b1;
                    cpu_enable_d = 1'b0;
                    state_d      = ST_SEND;
                    byte_idx_d   = 2'd0;
                    tx_start_d   = 1'b1;
                    tx_data_d    = count_inc[7:0];
                end
            end

            ST_STEP_IDLE: begin
                cpu_enable_d = 1'b0;
                if (dbg.rx_done) begin
                    if (dbg.rx_data == CMD_STEP) begin
                        state_d      = ST_STEP_EXEC;
                        cpu_enable_d = 1'b1;
                    end else if (dbg.rx_data == CMD_REPROGRAM) begin
                        start_prog = 1'b1;
                    end
                end
            end

            ST_STEP_EXEC: begin
                cycle_count_d = count_inc;
                cpu_enable_d  = 1'b0;
                if (dbg.halt_detected) begin
                    halted_d = 1'b1;
                end
                state_d    = ST_SEND;
                byte_idx_d = 2'd0;
                tx_start_d = 1'b1;
                tx_data_d  = count_inc[7:0];
            end

            ST_SEND: begin
                if (dbg.tx_done) begin
                    if (byte_idx_q == 2'd3) begin
                        tx_start_d = 1'b0;
                        byte_idx_d = 2'd0;
                        state_d    = halted_q ? ST_DONE : ST_STEP_IDLE;
                    end else begin
                        byte_idx_d = next_idx;
                        tx_start_d = 1'b1;
                        tx_data_d  = cycle_count_q[{next_idx, 3'b000} +: 8];
                    end
                end
            end

            ST_DONE: begin
                cpu_enable_d = 1'b0;
                if (dbg.rx_done && dbg.rx_data == CMD_REPROGRAM) begin
                    start_prog = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Common entry into program loading from IDLE, WAIT_MODE,
        // STEP_IDLE and DONE.
        if (start_prog) begin
            state_d       = ST_PROG;
            imem_addr_d   = '0;
            byte_idx_d    = 2'd0;
            cycle_count_d = '0;
            halted_d      = 1'b0;
            cpu_reset_d   = 1'b1;
            cpu_enable_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            byte_idx_q    <= 2'd0;
            cycle_count_q <= '0;
            halted_q      <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            cpu_enable_q  <= 1'b0;
            cpu_reset_q   <= 1'b1;
            imem_wr_en_q  <= 1'b0;
            imem_addr_q   <= '0;
            imem_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            cpu_enable_q  <= cpu_enable_d;
            cpu_reset_q   <= cpu_reset_d;
            imem_wr_en_q  <= imem_wr_en_d;
            imem_addr_q   <= imem_addr_d;
            imem_data_q   <= imem_data_d;
        end
    end

    assign dbg.tx_start   = tx_start_q;
    assign dbg.tx_data    = tx_data_q;
    assign dbg.cpu_enable = cpu_enable_q;
    assign dbg.cpu_reset  = cpu_reset_q;
    assign dbg.imem_wr_en = imem_wr_en_q;
    assign dbg.imem_addr  = imem_addr_q;
    assign dbg.imem_data  = imem_data_q;

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit -- scoreboard bench for debug_unit. Stimulus pushes expected
// IMEM writes and transmitted bytes into queues; monitor processes pop and
// compare whenever the DUT strobes a write or presents a tx byte.
module tb_debug_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    debug_unit_if #(.LEN(32), .ADDR_LEN(10)) bus ();

    debug_unit #(.LEN(32), .ADDR_LEN(10)) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (bus)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int tx_budget = 1000;
    bit tx_busy   = 1'b0;
    int en_total  = 0;
    int run_len   = 0;
    int max_run   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // IMEM write scoreboard and enable-pulse bookkeeping.
    always @(negedge clk) begin
        wr_t e;
        if (bus.cpu_enable) begin
            en_total++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (bus.imem_wr_en) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         bus.imem_addr, bus.imem_data);
            end else begin
                e = wr_q.pop_front();
                chk("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
                chk("imem_data", bus.imem_data, e.data);
            end
        end
    end

    // UART transmitter model: checks each presented byte, holds two cycles,
    // then pulses tx_done. Stops answering once tx_budget is exhausted.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.tx_start && tx_budget > 0) begin
                tx_busy = 1'b1;
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tx: byte 0x%0h, none expected", bus.tx_data);
                end else begin
                    chk("tx_data", 32'(bus.tx_data), 32'(tx_q.pop_front()));
                end
                tx_budget--;
                repeat (2) @(negedge clk);
                chk("tx_start_held", 32'(bus.tx_start), 32'd1);
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic load_word(input logic [9:0] addr, input logic [31:0] w);
        wr_t e;
        e.addr = addr;
        e.data = w;
        wr_q.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_count(input logic [31:0] c);
        for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
    endtask

    task automatic wait_writes();
        int t = 0;
        while (wr_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("writes_pending", 32'(wr_q.size()), 32'd0);
    endtask

    task automatic wait_tx();
        int t = 0;
        while ((tx_q.size() != 0 || bus.tx_start) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("tx_pending", 32'(tx_q.size()), 32'd0);
        chk("tx_start_idle", 32'(bus.tx_start), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_start"},   32'(bus.tx_start),   32'd0);
        chk({tag, "_tx_data"},    32'(bus.tx_data),    32'd0);
        chk({tag, "_cpu_enable"}, 32'(bus.cpu_enable), 32'd0);
        chk({tag, "_cpu_reset"},  32'(bus.cpu_reset),  32'd1);
        chk({tag, "_imem_wr_en"}, 32'(bus.imem_wr_en), 32'd0);
        chk({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        chk({tag, "_imem_data"},  bus.imem_data,       32'd0);
    endtask

    initial begin
        int k;
        int en0;
        int t;

        reset             = 1'b1;
        bus.rx_done       = 1'b0;
        bus.rx_data       = 8'h00;
        bus.halt_detected = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // STEP in IDLE is dropped; then load two words ending in halt.
        send_byte(8'h06);
        @(negedge clk);
        chk("idle_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("idle_cpu_enable", 32'(bus.cpu_enable), 32'd0);
        send_byte(8'h01);
        load_word(10'd0, 32'h2001_0020);
        load_word(10'd1, 32'hFFFF_FFFF);
        wait_writes();
        repeat (2) @(negedge clk);
        chk("wait_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("wait_cpu_enable", 32'(bus.cpu_enable), 32'd0);

        // Continuous run, halt during the 10th enabled cycle.
        push_count(32'd10);
        en0 = en_total;
        @(negedge clk);
        bus.rx_data = 8'h02;
        bus.rx_done = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && k < 10; i++) begin
            @(negedge clk);
            bus.rx_done = 1'b0;
            if (bus.cpu_enable) k++;
        end
        chk("run_enable_seen", 32'(k), 32'd10);
        bus.halt_detected = 1'b1;
        @(negedge clk);
        bus.halt_detected = 1'b0;
        chk("run_enable_drop", 32'(bus.cpu_enable), 32'd0);
        wait_tx();
        chk("run_enabled_cycles", 32'(en_total - en0), 32'd10);
        chk("done_cpu_enable", 32'(bus.cpu_enable), 32'd0);

        // STEP is ignored in DONE.
        en0 = en_total;
        send_byte(8'h06);
        repeat (4) @(negedge clk);
        chk("done_step_ignored", 32'(en_total - en0), 32'd0);
        chk("done_no_tx", 32'(bus.tx_start), 32'd0);

        // Reprogram from DONE; 0x02 inside a word is data, not a command.
        send_byte(8'h05);
        @(negedge clk);
        chk("reprog_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("reprog_cpu_enable", 32'(bus.cpu_enable), 32'd0);
        load_word(10'd0, 32'h0000_0002);
        load_word(10'd1, 32'hFC00_0000);
        wait_writes();

        // Step mode: three single-cycle pulses, counts 1..3. A STEP
        // received during the first SEND is dropped.
        send_byte(8'h03);
        @(negedge clk);
        chk("step_idle_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        chk("step_idle_cpu_enable", 32'(bus.cpu_enable), 32'd0);
        @(negedge clk);
        #1;
        max_run = 0;
        en0 = en_total;
        for (int s = 1; s <= 3; s++) begin
            push_count(32'(s));
            send_byte(8'h06);
            if (s == 1) send_byte(8'h06);
            wait_tx();
        end
        repeat (3) @(negedge clk);
        chk("step_pulses", 32'(en_total - en0), 32'd3);
        chk("step_pulse_width", 32'(max_run), 32'd1);

        // Reset during the second instruction byte.
        send_byte(8'h05);
        send_byte(8'h11);
        @(negedge clk);
        bus.rx_data = 8'h22;
        bus.rx_done = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        check_reset_outputs("rst_prog");
        reset = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        repeat (4) @(negedge clk);
        chk("rst_prog_idle_reset", 32'(bus.cpu_reset), 32'd1);

        // Reset while the third count byte awaits tx_done.
        send_byte(8'h01);
        load_word(10'd0, 32'hFFFF_FFFF);
        wait_writes();
        send_byte(8'h03);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h00);
        tx_budget = 2;
        send_byte(8'h06);
        t = 0;
        while (!(tx_budget == 0 && !tx_busy && bus.tx_start) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send3_tx_start", 32'(bus.tx_start), 32'd1);
        chk("send3_tx_data", 32'(bus.tx_data), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_send");
        reset = 1'b0;
        tx_budget = 1000;
        repeat (5) @(negedge clk);
        chk("rst_send_tx_quiet", 32'(bus.tx_start), 32'd0);

        chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
# debug_unit

Byte-level command and loader controller between the debug UART receiver/transmitter and the MIPS pipeline in `top_modular`. It consumes the host byte stream: start, 32-bit instructions sent LSB first, then run-mode commands. It writes the program into instruction memory and gates the pipeline clock-enable for continuous or step-by-step execution. It reports the executed cycle count back over UART.

## Interface
Parameters:
- `LEN`, 32: instruction/data width.
- `ADDR_LEN`, 10: instruction-memory word-address width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_done` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received byte.
- `tx_start` out 1: held high while `tx_data` awaits transmission.
- `tx_data` out 8: byte to transmit.
- `tx_done` in 1: one-cycle pulse, current byte sent.
- `halt_detected` in 1: pipeline retired the halt instruction.
- `cpu_enable` out 1: pipeline advance enable.
- `cpu_reset` out 1: pipeline reset, active-high.
- `imem_wr_en` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_LEN: word address.
- `imem_data` out LEN: assembled instruction.

## Operation
- Command bytes: START 0x01, CONTINUOUS 0x02, STEP_MODE 0x03, REPROGRAM 0x05, STEP 0x06. Bytes not listed for the current state are dropped.
- IDLE: `cpu_reset`=1, `cpu_enable`=0. START moves to PROG and clears `imem_addr`, byte index and `cycle_count`.
- PROG: each `rx_done` loads byte k (k=0..3) into `imem_data[8k+7:8k]`.
  - After byte 3, go to WRITE.
  - `cpu_reset`=1.
- WRITE: `imem_wr_en`=1 for exactly one cycle at the current `imem_addr`; the address increments afterward.
  - If `imem_data[31:26]`==6'b111111 (halt), go to WAIT_MODE. Otherwise return to PROG with k=0.
  - The address wraps from 2^ADDR_LEN−1 to 0 without error.
- WAIT_MODE (`cpu_reset`=1):
  - CONTINUOUS goes to RUN.
  - STEP_MODE goes to STEP_IDLE.
  - REPROGRAM goes to PROG (address 0, count cleared).
- RUN: `cpu_reset`=0, `cpu_enable`=1, `cycle_count`+1 per enabled cycle. `halt_detected` sets the `halted` flag and moves to SEND, with `cpu_enable` dropping the next cycle. Bytes received in RUN are dropped.
- STEP_IDLE (`cpu_reset`=0, `cpu_enable`=0):
  - STEP goes to STEP_EXEC.
  - REPROGRAM goes to PROG, with `cpu_reset` reasserted.
- STEP_EXEC: `cpu_enable`=1 for exactly one cycle, `cycle_count`+1, then SEND. A `halt_detected` sampled in this cycle sets `halted`.
- SEND: transmits `cycle_count` (32 bits) as 4 bytes, LSB first.
  - Per byte: `tx_data`=byte and `tx_start`=1, held until the `tx_done` pulse. In the cycle after `tx_done`, either the next byte is presented, or, after the 4th byte, `tx_start`=0.
  - After the 4th byte: DONE if `halted`, otherwise STEP_IDLE.
  - Bytes received in SEND are dropped.
- DONE: `cpu_enable`=0, pipeline state held. REPROGRAM goes to PROG, reasserts `cpu_reset`, and clears `halted` and `cycle_count`.
- `cycle_count` is 32 bits and wraps modulo 2^32.

## Timing
- All outputs are registered. Reset values: `tx_start`=0, `tx_data`=0, `cpu_enable`=0, `cpu_reset`=1, `imem_wr_en`=0, `imem_addr`=0, `imem_data`=0, state IDLE, `cycle_count`=0, `halted`=0.
- `reset` asserted in any state, including mid-byte in PROG or mid-transmission in SEND, returns everything to reset values on the next edge. A pending `tx_start` is dropped.
- `imem_wr_en` is asserted in the cycle after the 4th-byte `rx_done`, with stable `imem_addr`/`imem_data`.
- `cpu_enable` rises in the cycle after the CONTINUOUS/STEP `rx_done`.
- In RUN, the cycle in which `halt_detected` is sampled still counts. `cpu_enable`=0 from the next cycle.
- `rx_done` and `tx_done` in the same cycle: `tx_done` is honored, `rx_done` is dropped (only SEND consumes `tx_done`).

## Test plan
- Reset, then `rx_data`=0x01, then bytes 0x20,0x00,0x01,0x20 followed by 0xFF,0xFF,0xFF,0xFF → two `imem_wr_en` pulses: addr 0 data 0x20010020, addr 1 data 0xFFFFFFFF. State reaches WAIT_MODE with `cpu_reset`=1.
- After load, send 0x02 with `halt_detected` pulsed after 10 enabled cycles → `cpu_enable` high 10 cycles, then `tx_data` sequence 0x0A,0x00,0x00,0x00, each held until `tx_done`. DONE with `cpu_enable`=0.
- After load, send 0x03 then 0x06 three times → three single-cycle `cpu_enable` pulses. Counts transmitted: 0x01, 0x02, 0x03 (upper bytes 0x00).
- In DONE, send 0x05 and a new two-word program → `cpu_reset`=1, writes restart at addr 0, count restarts from 0.
- Assert `reset` during the 2nd instruction byte and during the 3rd SEND byte → all outputs return to reset values next cycle. No `imem_wr_en`, `tx_start`=0.
- Bytes 0x06 in IDLE and 0x02 during PROG byte collection → 0x06 is dropped; 0x02 is taken as instruction data, not as a command.
